// File: rtl/vga_pkg.sv
// Shared definitions for the VGA card CPU bus responder: register map,
// opcodes, status bit positions and the opcode argument-count table.
package vga_pkg;

    localparam logic [3:0] REG_MODE   = 4'h0;
    localparam logic [3:0] REG_OPCODE = 4'h1;
    localparam logic [3:0] REG_ARG0   = 4'h2;
    localparam logic [3:0] REG_STATUS = 4'hF;

    localparam logic [7:0] OP_TEXT_WRITE    = 8'h00;
    localparam logic [7:0] OP_TEXT_POSITION = 8'h01;
    localparam logic [7:0] OP_TEXT_CLEAR    = 8'h02;
    localparam logic [7:0] OP_WRITE_PIXEL   = 8'h10;

    localparam int ST_READY      = 7;
    localparam int ST_OVERRUN    = 2;
    localparam int ST_BAD_OPCODE = 1;
    localparam int ST_BUSY       = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } disp_state_e;

    // Number of argument bytes an opcode takes; 0 marks an unknown opcode.
    function automatic logic [3:0] arg_count(input logic [7:0] op);
        case (op)
            OP_TEXT_WRITE:    arg_count = 4'd2;
            OP_TEXT_POSITION: arg_count = 4'd2;
            OP_TEXT_CLEAR:    arg_count = 4'd1;
            OP_WRITE_PIXEL:   arg_count = 4'd1;
            default:          arg_count = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_bus_responder_bus_sync.sv
// Multi-stage synchronizer for the packed CPU bus pins plus a falling-edge
// detect on the synchronized phi2 bit. The whole bus goes through the same
// flops so address/data/control stay aligned with phi2 in the clk domain.
module bus_sync #(
    parameter int W        = 16,
    parameter int STAGES   = 2,
    parameter int PHI2_BIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         phi2_fall
);

    logic [STAGES-1:0][W-1:0] sync_q, sync_d;
    logic                     phi2_prev_q, phi2_prev_d;

    // Shift the raw pins down the chain; remember last synchronized phi2.
    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
        phi2_prev_d = sync_q[STAGES-1][PHI2_BIT];
    end

    // Synchronizer and edge-detect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            phi2_prev_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            phi2_prev_q <= phi2_prev_d;
        end
    end

    assign dout      = sync_q[STAGES-1];
    assign phi2_fall = phi2_prev_q & ~dout[PHI2_BIT];

endmodule

// File: rtl/cpu_bus_responder.sv
// 65C02 bus target for the VGA card. Reads are served combinationally from
// the raw pins; writes are synchronized into clk_25mhz, captured during the
// phi2 high phase and committed on the phi2 fall. A completed instruction is
// handed to the executor over a valid/ready handshake.
module cpu_bus_responder
    import vga_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_ARGS    = 13
) (
    input  logic                  clk_25mhz,
    input  logic                  reset,
    input  logic                  phi2,
    input  logic                  ce0,
    input  logic                  ce1b,
    input  logic                  rw,
    input  logic [3:0]            addr,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic                  data_oe,
    output logic [7:0]            mode,
    output logic                  instr_valid,
    output logic [7:0]            instr_opcode,
    output logic [8*NUM_ARGS-1:0] instr_args,
    input  logic                  instr_ready,
    input  logic                  exec_busy
);

    localparam int BUS_W = 16;

    logic [BUS_W-1:0] bus_raw, bus_s;
    logic             phi2_fall;
    logic             phi2_s, sel_s, rw_s;
    logic [3:0]       addr_s;
    logic [7:0]       data_s;

    logic [7:0]                mode_q, mode_d;
    logic [7:0]                opcode_q, opcode_d;
    logic [NUM_ARGS-1:0][7:0]  args_q, args_d;
    logic                      bad_opcode_q, bad_opcode_d;
    logic                      overrun_q, overrun_d;
    logic                      trig_pending_q, trig_pending_d;
    logic                      wr_pend_q, wr_pend_d;
    logic [3:0]                wr_addr_q, wr_addr_d;
    logic [7:0]                wr_data_q, wr_data_d;
    disp_state_e               state_q, state_d;

    logic       trigger;
    logic [3:0] wr_k, op_argc, rd_k;
    logic       busy;
    logic [7:0] status;

    assign bus_raw = {phi2, ce0, ce1b, rw, addr, data_in};

    bus_sync #(
        .W        (BUS_W),
        .STAGES   (SYNC_STAGES),
        .PHI2_BIT (BUS_W - 1)
    ) u_bus_sync (
        .clk       (clk_25mhz),
        .rst       (reset),
        .din       (bus_raw),
        .dout      (bus_s),
        .phi2_fall (phi2_fall)
    );

    assign phi2_s = bus_s[15];
    assign sel_s  = bus_s[14] & ~bus_s[13];
    assign rw_s   = bus_s[12];
    assign addr_s = bus_s[11:8];
    assign data_s = bus_s[7:0];

    assign instr_valid  = (state_q == S_PEND);
    assign instr_opcode = opcode_q;
    assign instr_args   = args_q;
    assign mode         = mode_q;

    // Write capture/commit, trigger decision and dispatch FSM next state.
    always_comb begin
        mode_d         = mode_q;
        opcode_d       = opcode_q;
        args_d         = args_q;
        bad_opcode_d   = bad_opcode_q;
        overrun_d      = overrun_q;
        trig_pending_d = trig_pending_q;
        wr_pend_d      = wr_pend_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        state_d        = state_q;
        trigger        = 1'b0;
        wr_k           = wr_addr_q - REG_ARG0;
        op_argc        = arg_count(opcode_q);

        case (state_q)
            S_IDLE: if (trig_pending_q) begin
                state_d        = S_PEND;
                trig_pending_d = 1'b0;
            end
            S_PEND: if (instr_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Keep re-sampling through the high phase so the commit uses the
        // last stable address/data, even if sel drops together with phi2.
        if (phi2_s && sel_s && !rw_s) begin
            wr_pend_d = 1'b1;
            wr_addr_d = addr_s;
            wr_data_d = data_s;
        end

        if (phi2_fall && wr_pend_q) begin
            wr_pend_d = 1'b0;
            if (wr_addr_q == REG_MODE) begin
                mode_d = wr_data_q;
            end else if (wr_addr_q == REG_OPCODE) begin
                // Opcode is part of the payload, so it is frozen while pending.
                if (state_q != S_PEND) begin
                    opcode_d     = wr_data_q;
                    bad_opcode_d = 1'b0;
                    overrun_d    = 1'b0;
                end
            end else if (wr_addr_q != REG_STATUS && int'(wr_k) < NUM_ARGS) begin
                if (state_q != S_PEND) args_d[wr_k] = wr_data_q;
                if (op_argc == 4'd0) begin
                    if (wr_addr_q == REG_ARG0) bad_opcode_d = 1'b1;
                end else if (4'(wr_k + 4'd1) == op_argc) begin
                    trigger = 1'b1;
                end
            end
        end

        // A trigger while something is still outstanding drops the new
        // instruction rather than corrupting the one in flight.
        if (trigger) begin
            if (state_q == S_PEND || exec_busy || trig_pending_q) overrun_d = 1'b1;
            else trig_pending_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            mode_q         <= '0;
            opcode_q       <= '0;
            args_q         <= '0;
            bad_opcode_q   <= 1'b0;
            overrun_q      <= 1'b0;
            trig_pending_q <= 1'b0;
            wr_pend_q      <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            state_q        <= S_IDLE;
        end else begin
            mode_q         <= mode_d;
            opcode_q       <= opcode_d;
            args_q         <= args_d;
            bad_opcode_q   <= bad_opcode_d;
            overrun_q      <= overrun_d;
            trig_pending_q <= trig_pending_d;
            wr_pend_q      <= wr_pend_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            state_q        <= state_d;
        end
    end

    assign busy = instr_valid | exec_busy | trig_pending_q;

    // Status byte and combinational read mux on the raw bus pins.
    always_comb begin
        status                = '0;
        status[ST_READY]      = ~reset;
        status[ST_OVERRUN]    = overrun_q;
        status[ST_BAD_OPCODE] = bad_opcode_q;
        status[ST_BUSY]       = busy;
        rd_k                  = addr - REG_ARG0;
        data_out              = '0;
        if (addr == REG_MODE)                   data_out = mode_q;
        else if (addr == REG_OPCODE)            data_out = opcode_q;
        else if (addr == REG_STATUS)            data_out = status;
        else if (int'(rd_k) < NUM_ARGS)         data_out = args_q[rd_k];
    end

    assign data_oe = ce0 & ~ce1b & rw & phi2;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed plus randomized bench for cpu_bus_responder. A byte-level model
// of the register file, status flags and dispatch count predicts every read.
module tb_cpu_bus_responder;

    localparam int NA = 13;

    logic              clk_25mhz = 1'b0;
    logic              reset, phi2, ce0, ce1b, rw;
    logic [3:0]        addr;
    logic [7:0]        data_in, data_out, mode, instr_opcode;
    logic              data_oe, instr_valid, instr_ready, exec_busy;
    logic [8*NA-1:0]   instr_args;

    cpu_bus_responder #(.SYNC_STAGES(2), .NUM_ARGS(NA)) dut (
        .clk_25mhz(clk_25mhz), .reset(reset), .phi2(phi2), .ce0(ce0), .ce1b(ce1b),
        .rw(rw), .addr(addr), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .mode(mode), .instr_valid(instr_valid), .instr_opcode(instr_opcode),
        .instr_args(instr_args), .instr_ready(instr_ready), .exec_busy(exec_busy)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int vectors = 0, miscompares = 0;

    // reference model state
    logic [7:0]      m_mode, m_op;
    logic [7:0]      m_args [NA];
    logic            m_bad, m_ovr, m_pending;
    int              exp_rise;
    logic [7:0]      exp_last_op;
    logic [8*NA-1:0] exp_last_args;

    // dispatch observer
    int              rise_cnt = 0;
    logic            prev_v = 1'b0;
    logic [7:0]      last_op = '0;
    logic [8*NA-1:0] last_args = '0;

    always @(negedge clk_25mhz) begin
        if (instr_valid && !prev_v) begin
            rise_cnt++;
            last_op   = instr_opcode;
            last_args = instr_args;
        end
        prev_v = instr_valid;
    end

    task automatic check(input string tag, input logic [8*NA-1:0] obs, input logic [8*NA-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_argc(input logic [7:0] op);
        case (op)
            8'h00, 8'h01: return 2;
            8'h02, 8'h10: return 1;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [7:0] m_reg(input logic [3:0] a);
        if (a == 4'h0) return m_mode;
        if (a == 4'h1) return m_op;
        if (a == 4'hF) return {1'b1, 4'b0, m_ovr, m_bad, m_pending | exec_busy};
        return m_args[int'(a) - 2];
    endfunction

    task automatic m_reset();
        m_mode = '0; m_op = '0; m_bad = 0; m_ovr = 0; m_pending = 0;
        for (int i = 0; i < NA; i++) m_args[i] = '0;
    endtask

    task automatic m_write(input logic [3:0] a, input logic [7:0] d);
        int k, n;
        if (a == 4'h0) m_mode = d;
        else if (a == 4'h1) begin
            if (!m_pending) begin m_op = d; m_bad = 0; m_ovr = 0; end
        end else if (a != 4'hF) begin
            k = int'(a) - 2;
            if (!m_pending) m_args[k] = d;
            n = m_argc(m_op);
            if (n == 0) begin
                if (k == 0) m_bad = 1;
            end else if (k + 1 == n) begin
                if (m_pending || exec_busy) m_ovr = 1;
                else begin
                    exp_rise++;
                    exp_last_op = m_op;
                    for (int i = 0; i < NA; i++) exp_last_args[8*i +: 8] = m_args[i];
                    if (!instr_ready) m_pending = 1;
                end
            end
        end
    endtask

    // One CPU write cycle at a random phase; optionally drop sel and scramble
    // the bus at the very instant phi2 falls.
    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d, input bit drop);
        #($urandom_range(0, 39));
        ce0 = 1; ce1b = 0; rw = 0; addr = a; data_in = d;
        #20 phi2 = 1;
        #($urandom_range(200, 280));
        phi2 = 0;
        if (drop) begin ce0 = 0; data_in = ~d; addr = ~a; end
        m_write(a, d);
        repeat (3) @(posedge clk_25mhz);
        #1;
        if (a == 4'h0) check("mode_commit_latency", {96'b0, mode}, {96'b0, d});
        ce0 = 0; rw = 1; data_in = $urandom;
        #150;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d, output logic oe);
        #($urandom_range(0, 39));
        ce0 = 1; ce1b = 0; rw = 1; addr = a;
        #20 phi2 = 1;
        #30 d = data_out; oe = data_oe;
        #170 phi2 = 0;
        ce0 = 0;
        #150;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        cpu_read(a, d, oe);
        check(tag, {96'b0, d}, {96'b0, exp});
        check({tag, "_oe"}, {103'b0, oe}, {103'b0, 1'b1});
    endtask

    initial begin
        logic [7:0] d;
        logic       oe;
        int         r0;
        logic [3:0] a;
        reset = 1; phi2 = 0; ce0 = 0; ce1b = 1; rw = 1; addr = 0; data_in = 0;
        instr_ready = 0; exec_busy = 0; exp_rise = 0;
        exp_last_op = '0; exp_last_args = '0;
        m_reset();
        repeat (3) @(posedge clk_25mhz);
        cpu_read(4'hF, d, oe);
        check("status_in_reset", {96'b0, d}, {96'b0, 8'h00});
        #5 reset = 0;
        repeat (2) @(posedge clk_25mhz);

        // 1: reset state, output enable gating
        rd_check("status_reset", 4'hF, 8'h80);
        rd_check("mode_reset", 4'h0, 8'h00);
        ce0 = 0; ce1b = 0; rw = 1; addr = 4'hF; phi2 = 1;
        #10 check("oe_ce0_low", {103'b0, data_oe}, {103'b0, 1'b0});
        phi2 = 0; ce1b = 1;
        #50;

        // 2: mode write
        cpu_write(4'h0, 8'h81, 0);
        rd_check("mode_rd", 4'h0, 8'h81);
        check("mode_port", {96'b0, mode}, {96'b0, 8'h81});
        check("no_dispatch_mode", rise_cnt, 0);

        // 3: TextWrite held pending by executor
        cpu_write(4'h1, 8'h00, 0);
        cpu_write(4'h2, 8'h0F, 0);
        cpu_write(4'h3, 8'h48, 0);
        rd_check("status_pend", 4'hF, 8'h81);
        check("valid_pend", {103'b0, instr_valid}, {103'b0, 1'b1});
        check("opcode_pend", {96'b0, instr_opcode}, {96'b0, 8'h00});
        check("args_pend", {88'b0, instr_args[15:0]}, {88'b0, 16'h480F});
        instr_ready = 1;
        repeat (2) @(posedge clk_25mhz);
        #1 m_pending = 0;
        check("valid_accepted", {103'b0, instr_valid}, {103'b0, 1'b0});
        rd_check("status_after_accept", 4'hF, 8'h80);
        instr_ready = 0;

        // 4: one-arg TextClear, then unknown opcode
        cpu_write(4'h1, 8'h02, 0);
        cpu_write(4'h2, 8'h07, 0);
        check("valid_clear", {103'b0, instr_valid}, {103'b0, 1'b1});
        check("args_clear", {96'b0, instr_args[7:0]}, {96'b0, 8'h07});
        instr_ready = 1;
        repeat (2) @(posedge clk_25mhz);
        #1 m_pending = 0;
        instr_ready = 0;
        r0 = rise_cnt;
        cpu_write(4'h1, 8'hFF, 0);
        cpu_write(4'h2, 8'h00, 0);
        rd_check("status_bad", 4'hF, 8'h82);
        check("no_dispatch_bad", rise_cnt, r0);
        cpu_write(4'h1, 8'h01, 0);
        rd_check("status_bad_clear", 4'hF, 8'h80);

        // 5: trigger while executor busy
        exec_busy = 1;
        cpu_write(4'h1, 8'h02, 0);
        cpu_write(4'h2, 8'h33, 0);
        rd_check("status_overrun", 4'hF, 8'h85);
        check("no_dispatch_busy", rise_cnt, r0);
        exec_busy = 0;
        rd_check("status_overrun_idle", 4'hF, m_reg(4'hF));

        // 6: reset while an instruction is pending
        cpu_write(4'h1, 8'h00, 0);
        cpu_write(4'h2, 8'hAA, 0);
        cpu_write(4'h3, 8'hBB, 0);
        check("valid_before_reset", {103'b0, instr_valid}, {103'b0, 1'b1});
        #7 reset = 1;
        #1 check("valid_async_reset", {103'b0, instr_valid}, {103'b0, 1'b0});
        m_reset();
        repeat (2) @(posedge clk_25mhz);
        #3 reset = 0;
        check("args_reset", instr_args, '0);
        rd_check("mode_after_reset", 4'h0, 8'h00);
        rd_check("opcode_after_reset", 4'h1, 8'h00);
        rd_check("arg0_after_reset", 4'h2, 8'h00);
        rd_check("status_after_reset", 4'hF, 8'h80);

        // randomized phase sweep with executor always ready
        instr_ready = 1;
        exp_rise = rise_cnt;
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0: a = 4'h0;
                1: a = 4'h1;
                2: a = 4'h2;
                3: a = 4'h3;
                default: a = 4'($urandom_range(0, 15));
            endcase
            if (a == 4'h1) begin
                case ($urandom_range(0, 4))
                    0: d = 8'h00; 1: d = 8'h01; 2: d = 8'h02; 3: d = 8'h10;
                    default: d = 8'($urandom);
                endcase
            end else d = 8'($urandom);
            cpu_write(a, d, bit'($urandom_range(0, 1)));
            rd_check("sweep_reg", a, m_reg(a));
            rd_check("sweep_status", 4'hF, m_reg(4'hF));
        end
        check("sweep_dispatch_count", rise_cnt, exp_rise);
        if (exp_rise > r0) begin
            check("sweep_last_op", {96'b0, last_op}, {96'b0, exp_last_op});
            check("sweep_last_args", last_args, exp_last_args);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
